demux1_2_stream: RTL and testbench
==================================

# demux1_2_stream

- Clocked 1-to-2 packet demultiplexer for valid/ready byte streams.
- Routes each packet from a single input stream to output 0 or output 1, chosen by `sel` on the packet's first beat.
- Holds the route until the last beat. Each output has its own register stage with full-throughput backpressure.
- Sits downstream of stream sources and feeds two independent consumers; it is the splitting counterpart of the team's 2:1 select path.

## Interface
Parameters:
- `DATA_W`, 8, data width of input and both outputs.
- `CNT_W`, 16, width of per-output packet counters.

Ports:
- `sys_clk`  in  1  single clock; all logic on rising edge.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `sel`  in  1  route select; 0 = output 0, 1 = output 1; sampled only on a packet's first beat.
- `in_data`  in  DATA_W  input beat data.
- `in_valid`  in  1  input beat valid.
- `in_last`  in  1  marks final beat of packet.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `out0_data` / `out1_data`  out  DATA_W  registered output data.
- `out0_valid` / `out1_valid`  out  1  output beat valid.
- `out0_last` / `out1_last`  out  1  output last marker.
- `out0_ready` / `out1_ready`  in  1  consumer ready.
- `busy`  out  1  high while mid-packet (state PKT).
- `cur_sel`  out  1  route of packet in progress (registered).
- `pkt_cnt0` / `pkt_cnt1`  out  CNT_W  packets delivered per output (see Configuration).

## Operation
- FSM states:
  - IDLE: route for the current beat = `sel` (combinational).
  - PKT: route for the current beat = `cur_sel`.
- IDLE -> PKT: a beat is accepted with `in_last`=0; `cur_sel` <= `sel`.
- PKT -> IDLE: a beat is accepted with `in_last`=1.
- A single-beat packet (first beat has `in_last`=1) stays in IDLE; `cur_sel` is still updated to `sel`.
- `sel` changes during PKT are ignored.
- Per-output register stage X (X = routed output):
  - `in_ready` = `!outX_valid | outX_ready`.
  - On accept: `outX_data`/`outX_last` <= input, `outX_valid` <= 1.
  - If `outX_valid & outX_ready` with no new load, `outX_valid` <= 0.
  - Load and drain in the same cycle keeps `outX_valid`=1 with the new beat.
- The non-routed output never loads; it still drains independently when its ready is high.
- `in_ready` depends only on the routed output, never on the other output.
- Output data/last hold stable while valid=1 and ready=0.

## Timing
- Reset values: state IDLE, `busy`=0, `cur_sel`=0, `out0_valid`=`out1_valid`=0, `out*_data`=0, `out*_last`=0, `pkt_cnt0`=`pkt_cnt1`=0.
- Latency: a beat accepted at edge N shows on `outX_valid` after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle with the routed ready held high.
- Back-to-back packets to different outputs: the next packet's first beat may be accepted the cycle after the previous `in_last` beat, with no bubble.
- Reset mid-packet: all valids drop on the reset edge, the FSM returns to IDLE, and in-flight/partial data is discarded. No recovery beat is emitted.
- `in_ready` is combinational from `outX_valid`, `outX_ready` and the route; there is no combinational path from `in_valid` to `in_ready`.

## Configuration
- Macro `DEMUX1_2_STREAM_CNT_EN`.
- Defined:
  - `pkt_cntX` increments by 1 on each cycle with `outX_valid & outX_ready & outX_last`.
  - Counters wrap modulo 2^CNT_W (all-ones + 1 -> 0) and clear on reset.
- Undefined: counter logic is not built; `pkt_cnt0`/`pkt_cnt1` are tied to 0; the port list is unchanged.

## Test plan
- Reset: assert `sys_rst_n`=0 for 2 cycles with `in_valid`=1 -> all outputs at reset values, no beats on either output.
- Routing: 3-beat packet 0x11,0x22,0x33 with `sel`=1 on beat 1 and `sel` toggled to 0 on beats 2-3 -> all three beats on output 1 in order, `out1_last` only on 0x33, output 0 idle, `busy` high from beat 1 accept to beat 3 accept.
- Backpressure: `out0_ready`=0 for 4 cycles during a 4-beat packet to output 0 -> `in_ready`=0 after one beat buffered, `out0_data` stable, no beat lost or duplicated after ready returns.
- Isolation: `out1_valid` stalled (`out1_ready`=0) while a packet targets output 0 -> `in_ready` follows `out0` only; full rate to output 0.
- Back-to-back single-beat packets alternating `sel` 0,1,0,1 at 1 beat/cycle, both readies high -> 4 accepts in 4 cycles, each appears on the correct output one cycle later with `last`=1.
- With `DEMUX1_2_STREAM_CNT_EN`, CNT_W=4: deliver 17 packets to output 0 -> `pkt_cnt0`=1 (wrapped), `pkt_cnt1`=0. Without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/demux1_2_stream_if.sv
// demux1_2_stream_if: valid/ready byte-stream bundle, one input stream and two output streams
interface demux1_2_stream_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] in_data, out0_data, out1_data;
  logic in_valid, in_last, in_ready;
  logic out0_valid, out0_last, out0_ready;
  logic out1_valid, out1_last, out1_ready;
  modport master (
    output in_data, in_valid, in_last, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out0_last, out1_data, out1_valid, out1_last
  );
  modport slave (
    input  in_data, in_valid, in_last, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out0_last, out1_data, out1_valid, out1_last
  );
endinterface

// File: rtl/demux1_2_stream.sv
// demux1_2_stream: 1:2 packet demux with per-output register slice; DEMUX1_2_STREAM_CNT_EN adds packet counters
module demux1_2_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sel,
  demux1_2_stream_if.slave bus,
  output logic             busy,
  output logic             cur_sel,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state;
  logic route, acc, ld0, ld1;
  logic v0, v1, l0, l1;
  logic [DATA_W-1:0] d0, d1;
  // route is sampled from sel only on a packet's first beat
  always_comb begin
    route = (state == PKT) ? cur_sel : sel;
    bus.in_ready = route ? (!v1 | bus.out1_ready) : (!v0 | bus.out0_ready);
    acc = bus.in_valid & bus.in_ready;
    ld0 = acc & !route;
    ld1 = acc & route;
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cur_sel <= 1'b0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      l0      <= 1'b0;
      l1      <= 1'b0;
      d0      <= '0;
      d1      <= '0;
    end else begin
      if (acc) begin
        state <= bus.in_last ? IDLE : PKT;
        if (state == IDLE) cur_sel <= sel;
      end
      if (ld0) begin
        v0 <= 1'b1;
        d0 <= bus.in_data;
        l0 <= bus.in_last;
      end else if (bus.out0_ready) v0 <= 1'b0;
      if (ld1) begin
        v1 <= 1'b1;
        d1 <= bus.in_data;
        l1 <= bus.in_last;
      end else if (bus.out1_ready) v1 <= 1'b0;
    end
  end
  assign busy           = (state == PKT);
  assign bus.out0_valid = v0;
  assign bus.out0_data  = d0;
  assign bus.out0_last  = l0;
  assign bus.out1_valid = v1;
  assign bus.out1_data  = d1;
  assign bus.out1_last  = l1;
`ifdef DEMUX1_2_STREAM_CNT_EN
  // counts completed deliveries, wrapping naturally at 2^CNT_W
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (v0 & bus.out0_ready & l0) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (v1 & bus.out1_ready & l1) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif
endmodule

// File: tb/tb_demux1_2_stream.sv
// tb_demux1_2_stream: table-driven check of routing, backpressure, isolation, reset and counters
module tb_demux1_2_stream;
`ifdef DEMUX1_2_STREAM_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic busy, cur_sel;
  logic [3:0] cnt0, cnt1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  demux1_2_stream_if #(.DATA_W(8)) bus();
  demux1_2_stream #(.DATA_W(8), .CNT_W(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .sel(sel), .bus(bus),
    .busy(busy), .cur_sel(cur_sel), .pkt_cnt0(cnt0), .pkt_cnt1(cnt1)
  );
  typedef struct {
    logic s, v, l; logic [7:0] d; logic r0, r1, rdy;
    logic v0; logic [7:0] d0; logic l0;
    logic v1; logic [7:0] d1; logic l1;
    logic b, cs;
  } vec_t;
  vec_t vt[23];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic drive(input logic s, v, l, input logic [7:0] d, input logic r0, r1);
    sel = s; bus.in_valid = v; bus.in_last = l; bus.in_data = d;
    bus.out0_ready = r0; bus.out1_ready = r1;
  endtask
  task automatic outs(input string t, input logic v0, input logic [7:0] d0, input logic l0,
                      input logic v1, input logic [7:0] d1, input logic l1, input logic b, cs);
    chk({t, "_v0"}, 32'(bus.out0_valid), 32'(v0));
    chk({t, "_d0"}, 32'(bus.out0_data), 32'(d0));
    chk({t, "_l0"}, 32'(bus.out0_last), 32'(l0));
    chk({t, "_v1"}, 32'(bus.out1_valid), 32'(v1));
    chk({t, "_d1"}, 32'(bus.out1_data), 32'(d1));
    chk({t, "_l1"}, 32'(bus.out1_last), 32'(l1));
    chk({t, "_busy"}, 32'(busy), 32'(b));
    chk({t, "_cursel"}, 32'(cur_sel), 32'(cs));
  endtask
  initial begin
    vt[0]  = '{1,1,0,8'h11,1,1,1, 0,8'h00,0, 1,8'h11,0, 1,1};
    vt[1]  = '{0,1,0,8'h22,1,1,1, 0,8'h00,0, 1,8'h22,0, 1,1};
    vt[2]  = '{0,1,1,8'h33,1,1,1, 0,8'h00,0, 1,8'h33,1, 0,1};
    vt[3]  = '{0,0,0,8'h00,1,1,1, 0,8'h00,0, 0,8'h33,1, 0,1};
    vt[4]  = '{0,1,0,8'hA1,0,1,1, 1,8'hA1,0, 0,8'h33,1, 1,0};
    vt[5]  = '{0,1,0,8'hA2,0,1,0, 1,8'hA1,0, 0,8'h33,1, 1,0};
    vt[6]  = '{0,1,0,8'hA2,0,1,0, 1,8'hA1,0, 0,8'h33,1, 1,0};
    vt[7]  = '{0,1,0,8'hA2,0,1,0, 1,8'hA1,0, 0,8'h33,1, 1,0};
    vt[8]  = '{0,1,0,8'hA2,1,1,1, 1,8'hA2,0, 0,8'h33,1, 1,0};
    vt[9]  = '{0,1,0,8'hA3,1,1,1, 1,8'hA3,0, 0,8'h33,1, 1,0};
    vt[10] = '{0,1,1,8'hA4,1,1,1, 1,8'hA4,1, 0,8'h33,1, 0,0};
    vt[11] = '{0,0,0,8'h00,1,1,1, 0,8'hA4,1, 0,8'h33,1, 0,0};
    vt[12] = '{1,1,1,8'hB0,1,0,1, 0,8'hA4,1, 1,8'hB0,1, 0,1};
    vt[13] = '{0,1,0,8'hC1,1,0,1, 1,8'hC1,0, 1,8'hB0,1, 1,0};
    vt[14] = '{1,1,0,8'hC2,1,0,1, 1,8'hC2,0, 1,8'hB0,1, 1,0};
    vt[15] = '{1,1,1,8'hC3,1,0,1, 1,8'hC3,1, 1,8'hB0,1, 0,0};
    vt[16] = '{1,0,0,8'h00,1,0,0, 0,8'hC3,1, 1,8'hB0,1, 0,0};
    vt[17] = '{1,0,0,8'h00,1,1,1, 0,8'hC3,1, 0,8'hB0,1, 0,0};
    vt[18] = '{0,1,1,8'h01,1,1,1, 1,8'h01,1, 0,8'hB0,1, 0,0};
    vt[19] = '{1,1,1,8'h02,1,1,1, 0,8'h01,1, 1,8'h02,1, 0,1};
    vt[20] = '{0,1,1,8'h03,1,1,1, 1,8'h03,1, 0,8'h02,1, 0,0};
    vt[21] = '{1,1,1,8'h04,1,1,1, 0,8'h03,1, 1,8'h04,1, 0,1};
    vt[22] = '{0,0,0,8'h00,1,1,1, 0,8'h03,1, 0,8'h04,1, 0,1};
    // reset held two cycles with a valid beat pending
    drive(1, 1, 0, 8'hFF, 1, 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs("reset", 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    chk("reset_cnt0", 32'(cnt0), 0);
    chk("reset_cnt1", 32'(cnt1), 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 8'h00, 1, 1);
    @(posedge clk);
    #1;
    outs("post_reset", 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 23; i++) begin
      drive(vt[i].s, vt[i].v, vt[i].l, vt[i].d, vt[i].r0, vt[i].r1);
      #2;
      chk($sformatf("v%0d_rdy", i), 32'(bus.in_ready), 32'(vt[i].rdy));
      @(posedge clk);
      #1;
      outs($sformatf("v%0d", i), vt[i].v0, vt[i].d0, vt[i].l0, vt[i].v1, vt[i].d1, vt[i].l1, vt[i].b, vt[i].cs);
    end
    chk("tbl_cnt0", 32'(cnt0), 32'(CNT_ON * 4));
    chk("tbl_cnt1", 32'(cnt1), 32'(CNT_ON * 4));
    // mid-packet reset discards the partial packet
    drive(0, 1, 0, 8'h55, 1, 1);
    @(posedge clk);
    #1;
    outs("mid_pkt", 1, 8'h55, 0, 0, 8'h04, 1, 1, 0);
    drive(1, 1, 0, 8'h56, 1, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    outs("mid_rst", 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    chk("mid_rst_cnt0", 32'(cnt0), 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 8'h00, 1, 1);
    @(posedge clk);
    #1;
    outs("after_rst", 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    // 17 single-beat packets to output 0 wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 1, 8'(8'h10 + i), 1, 1);
      #2;
      chk($sformatf("wrap%0d_rdy", i), 32'(bus.in_ready), 1);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 8'h00, 1, 1);
    @(posedge clk);
    #1;
    outs("wrap_end", 0, 8'h20, 1, 0, 8'h00, 0, 0, 0);
    chk("wrap_cnt0", 32'(cnt0), 32'(CNT_ON));
    chk("wrap_cnt1", 32'(cnt1), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
